// File: rtl/ddr_rd_prefetch.sv
// ---------------------------------------------------------------------------
// ddr_rd_prefetch
//   Read-side prefetch stage for the SDRAM controller. While the user has
//   prefetching enabled and the local FIFO has room for a whole burst, it
//   requests a burst from the read engine. Every acknowledged data word of
//   that burst is captured into the FIFO. At the end of each burst the start
//   address advances by BURST_LEN and wraps inside [ADDR_BASE, ADDR_LIMIT).
//   Buffered words are served to the user through a pop/valid port.
//
// Optional feature (compile-time macro):
//   DDR_RD_FIFO_CNT_EN - adds output rd_fifo_cnt_o, the registered FIFO count.
//
// Ports
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   init_end_i            SDRAM initialisation complete
//   rd_req_en_i           user enables prefetching
//   rd_addr_rst_i         restart the address window at ADDR_BASE
//   rd_ack_i, rd_data_i   data strobe and data word from the read engine
//   rd_end_i              burst-complete pulse from the read engine
//   rd_en_o               burst request to the read engine
//   rd_addr_o             burst start address {ba,row,col}
//   rd_burst_len_o        constant burst length
//   usr_rd_i              user pop request
//   usr_data_o/valid_o    popped word, valid one cycle after an accepted pop
//   fifo_empty_o/full_o   registered FIFO status
//   ovf_err_o             sticky: push attempted while the FIFO was full
//   rd_fifo_cnt_o         (DDR_RD_FIFO_CNT_EN only) FIFO word count
// ---------------------------------------------------------------------------
module ddr_rd_prefetch #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_AW    = 10,
  parameter int unsigned BURST_LEN  = 10,
  parameter logic [23:0] ADDR_BASE  = 24'd0,
  parameter logic [23:0] ADDR_LIMIT = 24'd1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end_i,
  input  logic              rd_req_en_i,
  input  logic              rd_addr_rst_i,
  input  logic              rd_ack_i,
  input  logic              rd_end_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              rd_en_o,
  output logic [23:0]       rd_addr_o,
  output logic [9:0]        rd_burst_len_o,
  input  logic              usr_rd_i,
  output logic [DATA_W-1:0] usr_data_o,
  output logic              usr_valid_o,
  output logic              fifo_empty_o,
  output logic              fifo_full_o,
`ifdef DDR_RD_FIFO_CNT_EN
  output logic [FIFO_AW:0]  rd_fifo_cnt_o,
`endif
  output logic              ovf_err_o
);

  localparam int unsigned      DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] BURST_C = (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [24:0]      BURST_A = 25'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_nxt, free;
  logic               push_req, push, pop;
  logic               addr_rst_pend;
  logic [24:0]        addr_sum;
  logic [23:0]        addr_next;

  assign rd_burst_len_o = 10'(BURST_LEN);
  assign free           = DEPTH_C - count;
  assign rd_en_o        = (state == REQ);

  // Only acks belonging to a requested burst are captured; a push into a
  // full FIFO is dropped and flagged instead of corrupting stored data.
  assign push_req = rd_ack_i && (state == REQ || state == BURST);
  assign push     = push_req && !fifo_full_o;
  assign pop      = usr_rd_i && !fifo_empty_o;

  // -------------------------------------------------------------------------
  // Burst sequencing FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of all others.
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (init_end_i && rd_req_en_i && free >= BURST_C) state_nxt = REQ;
      REQ:     if (rd_ack_i) state_nxt = BURST;
      BURST:   if (rd_end_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Address window. The sum is one bit wider than the address so a window
  // ending at the top of the 24-bit space still compares correctly.
  // -------------------------------------------------------------------------
  assign addr_sum  = {1'b0, rd_addr_o} + BURST_A;
  assign addr_next = (addr_sum >= {1'b0, ADDR_LIMIT}) ? ADDR_BASE : addr_sum[23:0];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_addr_o     <= ADDR_BASE;
      addr_rst_pend <= 1'b0;
    end else if (state == IDLE) begin
      if (rd_addr_rst_i) rd_addr_o <= ADDR_BASE;
    end else if (state == BURST && rd_end_i) begin
      // A restart requested during the burst replaces the increment.
      rd_addr_o     <= (addr_rst_pend || rd_addr_rst_i) ? ADDR_BASE : addr_next;
      addr_rst_pend <= 1'b0;
    end else if (rd_addr_rst_i) begin
      addr_rst_pend <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: the storage array has no reset; validity is tracked entirely by
  // the pointers and count, which are reset.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= rd_data_i;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_empty_o <= 1'b1;
      fifo_full_o  <= 1'b0;
      usr_data_o   <= '0;
      usr_valid_o  <= 1'b0;
      ovf_err_o    <= 1'b0;
    end else begin
      // Pointers wrap naturally at 2**FIFO_AW.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        usr_data_o <= mem[rd_ptr];
      end
      usr_valid_o  <= pop;
      count        <= count_nxt;
      fifo_empty_o <= (count_nxt == '0);
      fifo_full_o  <= (count_nxt == DEPTH_C);
      if (push_req && fifo_full_o) ovf_err_o <= 1'b1;
    end
  end

`ifdef DDR_RD_FIFO_CNT_EN
  assign rd_fifo_cnt_o = count;
`endif

endmodule

// File: tb/tb_ddr_rd_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_prefetch
//   Drives ddr_rd_prefetch with a randomised read-engine model (random ack
//   latency, gaps and data) and random user pops. Expected FIFO contents are
//   kept in a queue and expected burst addresses are computed arithmetically
//   from the window rules. Define DDR_RD_FIFO_CNT_EN to also check the count.
// ---------------------------------------------------------------------------
module tb_ddr_rd_prefetch;

  localparam int          BL    = 10;
  localparam int          DEPTH = 1024;
  localparam logic [23:0] BASE  = 24'd0;
  localparam int          LIMIT = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end_i = 1'b0;
  logic        rd_req_en_i = 1'b0;
  logic        rd_addr_rst_i = 1'b0;
  logic        rd_ack_i = 1'b0;
  logic        rd_end_i = 1'b0;
  logic [15:0] rd_data_i = '0;
  logic        usr_rd_i = 1'b0;
  logic        rd_en_o;
  logic [23:0] rd_addr_o;
  logic [9:0]  rd_burst_len_o;
  logic [15:0] usr_data_o;
  logic        usr_valid_o;
  logic        fifo_empty_o;
  logic        fifo_full_o;
  logic        ovf_err_o;
`ifdef DDR_RD_FIFO_CNT_EN
  logic [10:0] rd_fifo_cnt_o;
`endif

  ddr_rd_prefetch dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .init_end_i     (init_end_i),
    .rd_req_en_i    (rd_req_en_i),
    .rd_addr_rst_i  (rd_addr_rst_i),
    .rd_ack_i       (rd_ack_i),
    .rd_end_i       (rd_end_i),
    .rd_data_i      (rd_data_i),
    .rd_en_o        (rd_en_o),
    .rd_addr_o      (rd_addr_o),
    .rd_burst_len_o (rd_burst_len_o),
    .usr_rd_i       (usr_rd_i),
    .usr_data_o     (usr_data_o),
    .usr_valid_o    (usr_valid_o),
    .fifo_empty_o   (fifo_empty_o),
    .fifo_full_o    (fifo_full_o),
`ifdef DDR_RD_FIFO_CNT_EN
    .rd_fifo_cnt_o  (rd_fifo_cnt_o),
`endif
    .ovf_err_o      (ovf_err_o)
  );

  always #3 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_q[$];
  logic [23:0] exp_addr = BASE;
  logic [15:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] next_addr(input logic [23:0] a);
    int s;
    s = int'(a) + BL;
    return (s >= LIMIT) ? BASE : 24'(s);
  endfunction

  function automatic bit rnd_pop(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // One clock cycle: apply inputs, update the reference queue, then check
  // the FIFO-side outputs just after the edge.
  task automatic step(input bit ack, input logic [15:0] d, input bit endp,
                      input bit pop, input bit arst);
    bit          popped;
    logic [15:0] exp_d;
    rd_ack_i      = ack;
    rd_data_i     = d;
    rd_end_i      = endp;
    usr_rd_i      = pop;
    rd_addr_rst_i = arst;
    popped        = 1'b0;
    exp_d         = '0;
    if (pop && model_q.size() > 0) begin
      exp_d     = model_q.pop_front();
      popped    = 1'b1;
      last_data = exp_d;
    end
    if (ack) model_q.push_back(d);
    @(posedge sys_clk);
    #1;
    rd_ack_i      = 1'b0;
    rd_data_i     = '0;
    rd_end_i      = 1'b0;
    usr_rd_i      = 1'b0;
    rd_addr_rst_i = 1'b0;
    check("usr_valid", usr_valid_o, popped);
    check(popped ? "usr_data" : "usr_hold", usr_data_o, popped ? exp_d : last_data);
    check("empty", fifo_empty_o, model_q.size() == 0);
    check("full", fifo_full_o, model_q.size() == DEPTH);
`ifdef DDR_RD_FIFO_CNT_EN
    check("fifo_cnt", rd_fifo_cnt_o, model_q.size());
`endif
  endtask

  // Acts as the read engine for one burst.
  task automatic run_burst(input bit seq_data, input int pop_pct,
                           input bit arst_mid, input bit drop_req_mid);
    int          waited;
    bit          pend;
    logic [15:0] dv;
    waited = 0;
    while (!rd_en_o && waited < 64) begin
      step(1'b0, '0, 1'b0, rnd_pop(pop_pct), 1'b0);
      waited++;
    end
    check("rd_en_start", rd_en_o, 1'b1);
    if (!rd_en_o) return;
    check("burst_addr", rd_addr_o, exp_addr);
    repeat ($urandom_range(0, 3)) begin
      step(1'b0, '0, 1'b0, rnd_pop(pop_pct), 1'b0);
      check("rd_en_hold", rd_en_o, 1'b1);
    end
    pend = 1'b0;
    for (int i = 0; i < BL; i++) begin
      if (i > 0) repeat ($urandom_range(0, 2)) step(1'b0, '0, 1'b0, rnd_pop(pop_pct), 1'b0);
      dv = seq_data ? 16'(i + 1) : 16'($urandom);
      step(1'b1, dv, 1'b0, rnd_pop(pop_pct), 1'b0);
      if (i == 0) check("rd_en_drop", rd_en_o, 1'b0);
      if (i == BL / 2) begin
        if (arst_mid) begin
          step(1'b0, '0, 1'b0, 1'b0, 1'b1);
          check("addr_stable", rd_addr_o, exp_addr);
          pend = 1'b1;
        end
        if (drop_req_mid) rd_req_en_i = 1'b0;
      end
    end
    step(1'b0, '0, 1'b1, rnd_pop(pop_pct), 1'b0);
    exp_addr = pend ? BASE : next_addr(exp_addr);
    check("end_addr", rd_addr_o, exp_addr);
  endtask

  initial begin
    int waited;

    // Reset values
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_rd_en", rd_en_o, 1'b0);
    check("rst_addr", rd_addr_o, BASE);
    check("rst_usr_data", usr_data_o, 16'h0);
    check("rst_usr_valid", usr_valid_o, 1'b0);
    check("rst_empty", fifo_empty_o, 1'b1);
    check("rst_full", fifo_full_o, 1'b0);
    check("rst_ovf", ovf_err_o, 1'b0);
    check("burst_len", rd_burst_len_o, 10'd10);
`ifdef DDR_RD_FIFO_CNT_EN
    check("rst_cnt", rd_fifo_cnt_o, 11'd0);
`endif
    sys_rst = 1'b0;

    // No requests before SDRAM initialisation completes
    rd_req_en_i = 1'b1;
    repeat (5) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("no_init", rd_en_o, 1'b0);
    end
    init_end_i = 1'b1;

    // First burst with data 1..10, then pop all ten in order
    run_burst(1'b1, 0, 1'b0, 1'b0);
    rd_req_en_i = 1'b0;
    repeat (BL) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);  // pop on empty
    rd_req_en_i = 1'b1;

    // Concurrent push/pop, then address restart requested mid-burst at 40
    run_burst(1'b0, 0, 1'b0, 1'b0);
    rd_req_en_i = 1'b0;
    repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    rd_req_en_i = 1'b1;
    run_burst(1'b0, 100, 1'b0, 1'b0);
    run_burst(1'b0, 0, 1'b0, 1'b0);
    check("pre_rst_addr", rd_addr_o, 24'd40);
    run_burst(1'b0, 0, 1'b1, 1'b0);
    check("mid_rst_addr", rd_addr_o, 24'd0);

    // Random mixed traffic; one burst loses its enable mid-way
    for (int b = 0; b < 16; b++) begin
      run_burst(1'b0, 50, 1'b0, b == 8);
      if (b == 8) begin
        repeat (10) begin
          step(1'b0, '0, 1'b0, rnd_pop(50), 1'b0);
          check("req_dropped", rd_en_o, 1'b0);
        end
        rd_req_en_i = 1'b1;
      end
    end

    // Drain, then restart the window while idle
    rd_req_en_i = 1'b0;
    while (model_q.size() > 0) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    exp_addr = BASE;
    check("idle_addr_rst", rd_addr_o, BASE);

    // Fill without pops: 102 bursts reach 1020 words, then no more requests
    rd_req_en_i = 1'b1;
    for (int b = 0; b < 102; b++) run_burst(1'b0, 0, 1'b0, 1'b0);
    check("fill_addr", rd_addr_o, 24'd1020);
    repeat (20) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("no_space", rd_en_o, 1'b0);
    end

    // Make room; next burst starts at 1020 and wraps to the base
    repeat (BL) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    run_burst(1'b0, 0, 1'b0, 1'b0);
    check("wrap_addr", rd_addr_o, 24'd0);

    // Reset asserted mid-burst
    repeat (20) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    waited = 0;
    while (!rd_en_o && waited < 64) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      waited++;
    end
    check("rst_burst_start", rd_en_o, 1'b1);
    repeat (3) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    check("ovf_clear", ovf_err_o, 1'b0);
    #2;
    sys_rst = 1'b1;
    #1;
    check("mid_rst_rd_en", rd_en_o, 1'b0);
    check("mid_rst_empty", fifo_empty_o, 1'b1);
    check("mid_rst_addr", rd_addr_o, BASE);
    check("mid_rst_valid", usr_valid_o, 1'b0);
    check("mid_rst_data", usr_data_o, 16'h0);
    model_q.delete();
    exp_addr    = BASE;
    last_data   = '0;
    rd_req_en_i = 1'b0;
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("post_rst_addr", rd_addr_o, BASE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
